// File: rtl/tf_provider_qw.sv
// -----------------------------------------------------------------------------
// tf_provider_qw
//
// Twiddle-factor provider for one radix stage of the streaming FFT.
// Issues W^k = cos(2*pi*k/TF_NUM) - j*sin(2*pi*k/TF_NUM) as {re,im} IEEE-754
// pairs. The values are rebuilt from an external quarter-wave ROM by folding
// the two MSBs of k into a quadrant.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous reset, active low
//   en             issue one twiddle this cycle
//   sync           frame restart; latches inv and rep_log
//   inv            conjugate output (IFFT), sampled with sync
//   rep_log        each twiddle is repeated 2^rep_log times, sampled with sync
//   rom_addr       quarter-ROM address (k modulo TF_NUM/4)
//   rom_en         quarter-ROM read enable
//   rom_data       {cos, sin} from the ROM, one cycle after rom_en
//   data_out       {re, im}; re is in the upper FLOAT_LEN bits
//   data_out_valid data_out carries a twiddle this cycle
//   data_out_last  final issue of a frame (k = TF_NUM-1, last repeat)
//
// Latency from the issuing edge to the output register is fixed, with no
// backpressure. data_out holds its value while data_out_valid is low.
// -----------------------------------------------------------------------------
module tf_provider_qw #(
    parameter int unsigned FLOAT_LEN    = 32,
    parameter int unsigned TF_LOG       = 6,
    parameter int unsigned ROM_ADDR_LEN = TF_LOG - 2,
    parameter int unsigned REP_W        = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      sync,
    input  logic                      inv,
    input  logic [REP_W-1:0]          rep_log,
    output logic [ROM_ADDR_LEN-1:0]   rom_addr,
    output logic                      rom_en,
    input  logic [2*FLOAT_LEN-1:0]    rom_data,
    output logic [2*FLOAT_LEN-1:0]    data_out,
    output logic                      data_out_valid,
    output logic                      data_out_last
);

    localparam int unsigned REP_CNT_W = (1 << REP_W) - 1;

    // Sign-bit flip; this is the only arithmetic the fold needs.
    function automatic logic [FLOAT_LEN-1:0] neg(input logic [FLOAT_LEN-1:0] x);
        return {~x[FLOAT_LEN-1], x[FLOAT_LEN-2:0]};
    endfunction

    // ---------------------------------------------------------------------
    // Issue counters and latched options
    // ---------------------------------------------------------------------
    logic [TF_LOG-1:0]    k_q, k_d, k_iss;
    logic [REP_CNT_W-1:0] cnt_q, cnt_d, cnt_iss, rep_max;
    logic                 inv_q, inv_eff;
    logic [REP_W-1:0]     rep_q, rep_eff;
    logic                 last_iss;

    // When sync is high, the issue uses (0,0) and the options being latched
    // in this same cycle. The step then continues from those values.
    always_comb begin
        rep_eff = sync ? rep_log : rep_q;
        inv_eff = sync ? inv     : inv_q;
        k_iss   = sync ? '0      : k_q;
        cnt_iss = sync ? '0      : cnt_q;

        rep_max = '0;
        for (int unsigned i = 0; i < REP_CNT_W; i++) begin
            rep_max[i] = (i < 32'(rep_eff));
        end

        last_iss = (&k_iss) && (cnt_iss == rep_max);

        k_d   = k_iss;
        cnt_d = cnt_iss;
        if (en) begin
            if (cnt_iss == rep_max) begin
                cnt_d = '0;
                k_d   = k_iss + TF_LOG'(1);
            end else begin
                cnt_d = cnt_iss + REP_CNT_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Pipeline registers
    // ---------------------------------------------------------------------
    logic [ROM_ADDR_LEN-1:0] rom_addr_q;
    logic                    rom_en_q;
    logic [1:0]              q1_q, q2_q;
    logic                    v1_q, v2_q;
    logic                    l1_q, l2_q;
    logic                    i1_q, i2_q;
    logic [2*FLOAT_LEN-1:0]  data_q, data_d;
    logic                    valid_q, last_q;

    // Quadrant fold of the registered ROM word.
    always_comb begin
        logic [FLOAT_LEN-1:0] c, s, re, im;
        c  = rom_data[2*FLOAT_LEN-1:FLOAT_LEN];
        s  = rom_data[FLOAT_LEN-1:0];
        re = c;
        im = neg(s);
        unique case (q2_q)
            2'd0: begin re = c;      im = neg(s); end
            2'd1: begin re = neg(s); im = neg(c); end
            2'd2: begin re = neg(c); im = s;      end
            2'd3: begin re = s;      im = c;      end
        endcase
        if (i2_q) begin
            im = neg(im);
        end
        data_d = {re, im};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q        <= '0;
            cnt_q      <= '0;
            inv_q      <= 1'b0;
            rep_q      <= '0;
            rom_addr_q <= '0;
            rom_en_q   <= 1'b0;
            q1_q       <= '0;
            v1_q       <= 1'b0;
            l1_q       <= 1'b0;
            i1_q       <= 1'b0;
            q2_q       <= '0;
            v2_q       <= 1'b0;
            l2_q       <= 1'b0;
            i2_q       <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            k_q   <= k_d;
            cnt_q <= cnt_d;
            if (sync) begin
                inv_q <= inv;
                rep_q <= rep_log;
            end

            // Stage 0: address the ROM and tag the issue
            rom_en_q <= en;
            if (en) begin
                rom_addr_q <= k_iss[TF_LOG-3:0];
                q1_q       <= k_iss[TF_LOG-1:TF_LOG-2];
            end
            v1_q <= en;
            l1_q <= en & last_iss;
            i1_q <= inv_eff;

            // Stage 1: tags wait alongside the ROM read
            q2_q <= q1_q;
            v2_q <= v1_q;
            l2_q <= l1_q;
            i2_q <= i1_q;

            // Stage 2: fold into the output register
            valid_q <= v2_q;
            last_q  <= v2_q & l2_q;
            if (v2_q) begin
                data_q <= data_d;
            end
        end
    end

    assign rom_addr       = rom_addr_q;
    assign rom_en         = rom_en_q;
    assign data_out       = data_q;
    assign data_out_valid = valid_q;
    assign data_out_last  = last_q;

endmodule

// File: tb/tb_tf_provider_qw.sv
// -----------------------------------------------------------------------------
// tb_tf_provider_qw
//
// Directed bench for tf_provider_qw (TF_LOG=6). Entry 0 of the quarter ROM is
// the true {1.0, 0.0}. The other entries are distinct patterns so that folding
// and addressing errors become visible bit-for-bit.
// -----------------------------------------------------------------------------
module tb_tf_provider_qw;

    localparam int FL = 32;
    localparam int TL = 6;
    localparam int RA = 4;
    localparam int RW = 4;
    localparam logic [31:0] SGN = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          sync = 1'b0;
    logic          inv = 1'b0;
    logic [RW-1:0] rep_log = '0;
    logic [RA-1:0] rom_addr;
    logic          rom_en;
    logic [63:0]   rom_data = '0;
    logic [63:0]   data_out;
    logic          data_out_valid;
    logic          data_out_last;

    always #5 clk = ~clk;

    tf_provider_qw #(
        .FLOAT_LEN   (FL),
        .TF_LOG      (TL),
        .ROM_ADDR_LEN(RA),
        .REP_W       (RW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .sync          (sync),
        .inv           (inv),
        .rep_log       (rep_log),
        .rom_addr      (rom_addr),
        .rom_en        (rom_en),
        .rom_data      (rom_data),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_last (data_out_last)
    );

    function automatic logic [63:0] rom_entry(input logic [3:0] j);
        if (j == 4'd0) return 64'h3F800000_00000000;
        return {32'h3F000000 | {20'h0, j, 8'h00}, 32'h3E000000 | {28'h0, j}};
    endfunction

    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_entry(rom_addr);
    end

    function automatic logic [63:0] exp_tf(input int k, input logic iv);
        logic [63:0] e;
        logic [31:0] c, s, re, im;
        e = rom_entry(4'(k % 16));
        c = e[63:32];
        s = e[31:0];
        case ((k / 16) % 4)
            0:       begin re = c;       im = s ^ SGN; end
            1:       begin re = s ^ SGN; im = c ^ SGN; end
            2:       begin re = c ^ SGN; im = s;       end
            default: begin re = s;       im = c;       end
        endcase
        if (iv) im = im ^ SGN;
        return {re, im};
    endfunction

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: counters, latched options, 3-deep output pipeline
    int          bk, bc, brep;
    logic        binv;
    logic        pv [3];
    logic        pl [3];
    logic [63:0] pd [3];
    logic [63:0] hold_d;
    logic [63:0] cap_d [$];
    logic        cap_l [$];
    logic [63:0] r1 [$];

    task automatic model_reset();
        bk = 0; bc = 0; brep = 0; binv = 1'b0; hold_d = '0;
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0; pl[i] = 1'b0; pd[i] = '0;
        end
    endtask

    // Drive one cycle from a negedge and check the outputs at the next negedge.
    task automatic tick(input logic e, input logic s);
        logic nv, nl;
        logic [63:0] nd;
        int rmax;
        en = e;
        sync = s;
        if (s) begin
            binv = inv; brep = int'(rep_log); bk = 0; bc = 0;
        end
        rmax = (1 << brep) - 1;
        nv = e; nl = 1'b0; nd = '0;
        if (e) begin
            nl = (bk == 63) && (bc == rmax);
            nd = exp_tf(bk, binv);
            if (bc == rmax) begin
                bc = 0; bk = (bk + 1) % 64;
            end else begin
                bc++;
            end
        end
        @(posedge clk);
        pv[2] = pv[1]; pl[2] = pl[1]; pd[2] = pd[1];
        pv[1] = pv[0]; pl[1] = pl[0]; pd[1] = pd[0];
        pv[0] = nv;    pl[0] = nl;    pd[0] = nd;
        @(negedge clk);
        check("valid", data_out_valid, pv[2]);
        if (pv[2]) begin
            check("data", data_out, pd[2]);
            check("last", data_out_last, pl[2]);
            hold_d = pd[2];
            cap_d.push_back(data_out);
            cap_l.push_back(data_out_last);
        end else begin
            check("hold", data_out, hold_d);
            check("last_idle", data_out_last, 1'b0);
        end
    endtask

    function automatic int count_last();
        int n = 0;
        foreach (cap_l[i]) if (cap_l[i] === 1'b1) n++;
        return n;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        model_reset();
        @(negedge clk);
        check("rst_data",  data_out, 64'h0);
        check("rst_valid", data_out_valid, 1'b0);
        check("rst_last",  data_out_last, 1'b0);
        check("rst_rom_en", rom_en, 1'b0);
        check("rst_rom_addr", rom_addr, 4'h0);
        rst = 1'b1;

        // Run 1: forward, no repeat
        inv = 1'b0; rep_log = 4'd0;
        cap_d.delete(); cap_l.delete();
        tick(1, 1);
        repeat (63) tick(1, 0);
        repeat (3) tick(0, 0);
        check("r1_count", cap_d.size(), 64);
        check("r1_k0",  cap_d[0],  64'h3F800000_80000000);
        check("r1_k16", cap_d[16], 64'h80000000_BF800000);
        check("r1_k32", cap_d[32], 64'hBF800000_00000000);
        check("r1_k48", cap_d[48], 64'h00000000_3F800000);
        check("r1_last_cnt", count_last(), 1);
        check("r1_last_pos", cap_l[63], 1'b1);
        r1 = cap_d;

        // Run 2: inverse; option changes after sync must be ignored
        inv = 1'b1;
        cap_d.delete(); cap_l.delete();
        tick(1, 1);
        inv = 1'b0; rep_log = 4'd3;
        repeat (63) tick(1, 0);
        repeat (3) tick(0, 0);
        check("r2_count", cap_d.size(), 64);
        check("r2_k0",  cap_d[0],  64'h3F800000_00000000);
        check("r2_k16", cap_d[16], 64'h80000000_3F800000);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (cap_d[i] !== (r1[i] ^ 64'h00000000_80000000)) bad++;
        end
        check("r2_im_flip", bad, 0);

        // Run 3: rep_log=2, frame of 256 then wrap
        inv = 1'b0; rep_log = 4'd2;
        cap_d.delete(); cap_l.delete();
        tick(1, 1);
        repeat (259) tick(1, 0);
        repeat (3) tick(0, 0);
        check("r3_count", cap_d.size(), 260);
        check("r3_out4", cap_d[3], 64'h3F800000_80000000);
        check("r3_out5", cap_d[4], 64'h3F000100_BE000001);
        check("r3_last_cnt", count_last(), 1);
        check("r3_last_pos", cap_l[255], 1'b1);
        check("r3_wrap", cap_d[256], 64'h3F800000_80000000);

        // Run 4: en toggling
        rep_log = 4'd0;
        cap_d.delete(); cap_l.delete();
        tick(1, 1);
        for (int i = 0; i < 40; i++) tick((i % 2) == 1, 0);
        repeat (3) tick(0, 0);
        check("r4_count", cap_d.size(), 21);
        check("r4_k20", cap_d[20], 64'hBE000004_BF000400);

        // Run 5: resync mid-frame at k=37, then sync without en
        cap_d.delete(); cap_l.delete();
        tick(1, 1);
        repeat (36) tick(1, 0);
        tick(1, 1);
        tick(0, 1);
        tick(1, 0);
        repeat (3) tick(0, 0);
        check("r5_count", cap_d.size(), 39);
        check("r5_k37", cap_d[36], exp_tf(36, 1'b0));
        check("r5_resync", cap_d[37], 64'h3F800000_80000000);
        check("r5_sync_noen", cap_d[38], 64'h3F800000_80000000);

        // Run 6: asynchronous reset with issues in flight
        tick(1, 1);
        repeat (22) tick(1, 0);
        rst = 1'b0;
        #1;
        check("r6_data",  data_out, 64'h0);
        check("r6_valid", data_out_valid, 1'b0);
        check("r6_last",  data_out_last, 1'b0);
        check("r6_rom_en", rom_en, 1'b0);
        model_reset();
        #2;
        rst = 1'b1;
        cap_d.delete(); cap_l.delete();
        tick(1, 1);
        repeat (4) tick(0, 0);
        check("r6_count", cap_d.size(), 1);
        check("r6_k0", cap_d[0], 64'h3F800000_80000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
